// File: rtl/max_rectangle_finder.sv
// Solver stage of the tile puzzle. It buffers the decoded tiles, then compares
// every unordered pair (i<j) and reports the largest rectangle area that has
// the two tiles as opposite, inclusive corners.
// MAX_TILES must be at least 2.
module max_rectangle_finder #(
    parameter int GRID_BITS = 17,
    parameter int MAX_TILES = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   end_of_file,
    input  logic                   tile_valid,
    input  logic [GRID_BITS-1:0]   tile_row,
    input  logic [GRID_BITS-1:0]   tile_col,
    output logic                   result_valid,
    output logic [2*GRID_BITS+1:0] result_area,
    output logic                   overflow
);

    localparam int IDX_BITS  = $clog2(MAX_TILES);
    localparam int CNT_BITS  = IDX_BITS + 1;
    localparam int AREA_BITS = 2 * GRID_BITS + 2;
    localparam int DIM_BITS  = GRID_BITS + 1;
    localparam int TILE_BITS = 2 * GRID_BITS;
    localparam logic [CNT_BITS-1:0] CAP = CNT_BITS'(MAX_TILES);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Control state
    state_t                state_q, state_d;
    logic [CNT_BITS-1:0]   count_q, count_d;
    logic [IDX_BITS-1:0]   i_q, i_d;
    logic [IDX_BITS-1:0]   j_q, j_d;
    logic                  anchor_phase_q, anchor_phase_d;
    logic                  result_valid_q, result_valid_d;
    logic [AREA_BITS-1:0]  result_area_q, result_area_d;
    logic                  overflow_q, overflow_d;

    // Control decode
    logic                  accept;
    logic [CNT_BITS-1:0]   n_after;
    logic                  wr_en;
    logic                  issue;
    logic [IDX_BITS-1:0]   rd_addr;

    // Tile RAM and pair pipeline
    logic [TILE_BITS-1:0]  mem [MAX_TILES];
    logic [TILE_BITS-1:0]  rd_data_q;
    logic [TILE_BITS-1:0]  anchor_q;
    logic                  load_anchor_q;
    logic                  rd_v_q, a_v_q, b_v_q;
    logic [GRID_BITS-1:0]  row_a, col_a, row_b, col_b;
    logic [DIM_BITS-1:0]   dr_d, dc_d, dr_q, dc_q;
    logic [AREA_BITS-1:0]  area_q;
    logic [AREA_BITS-1:0]  max_q;

    // Next-state logic: loading, pair sequencing, drain and result capture
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        state_d        = state_q;
        count_d        = count_q;
        i_d            = i_q;
        j_d            = j_q;
        anchor_phase_d = anchor_phase_q;
        result_valid_d = result_valid_q;
        result_area_d  = result_area_q;
        overflow_d     = overflow_q;
        wr_en          = 1'b0;
        issue          = 1'b0;
        rd_addr        = j_q;
        accept         = tile_valid && (count_q < CAP);
        n_after        = count_q + CNT_BITS'(accept);

        case (state_q)
            S_LOAD: begin
                wr_en   = accept;
                count_d = n_after;
                if (tile_valid && !accept) begin
                    overflow_d = 1'b1;
                end
                if (end_of_file) begin
                    i_d            = '0;
                    j_d            = '0;
                    anchor_phase_d = 1'b1;
                    if (n_after >= CNT_BITS'(2)) begin
                        state_d = S_SCAN;
                    end else begin
                        state_d        = S_DONE;
                        result_valid_d = 1'b1;
                        result_area_d  = '0;
                    end
                end
            end
            S_SCAN: begin
                if (anchor_phase_q) begin
                    // Stall pair issue for one cycle while tile i is fetched.
                    rd_addr        = i_q;
                    j_d            = i_q + IDX_BITS'(1);
                    anchor_phase_d = 1'b0;
                end else begin
                    issue = 1'b1;
                    if (CNT_BITS'(j_q) == count_q - CNT_BITS'(1)) begin
                        if (CNT_BITS'(i_q) == count_q - CNT_BITS'(2)) begin
                            state_d = S_DRAIN;
                        end else begin
                            i_d            = i_q + IDX_BITS'(1);
                            anchor_phase_d = 1'b1;
                        end
                    end else begin
                        j_d = j_q + IDX_BITS'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!(rd_v_q || a_v_q || b_v_q)) begin
                    result_area_d  = max_q;
                    result_valid_d = 1'b1;
                    state_d        = S_DONE;
                end
            end
            S_DONE: begin
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q        <= S_LOAD;
            count_q        <= '0;
            i_q            <= '0;
            j_q            <= '0;
            anchor_phase_q <= 1'b1;
            result_valid_q <= 1'b0;
            result_area_q  <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            i_q            <= i_d;
            j_q            <= j_d;
            anchor_phase_q <= anchor_phase_d;
            result_valid_q <= result_valid_d;
            result_area_q  <= result_area_d;
            overflow_q     <= overflow_d;
        end
    end

    // Tile RAM: one write port during load, one registered read port
    always_ff @(posedge clk) begin
        // NOTE: the RAM is not reset; the tile count alone decides which entries are live.
        if (wr_en) begin
            mem[count_q[IDX_BITS-1:0]] <= {tile_row, tile_col};
        end
        rd_data_q <= mem[rd_addr];
    end

    // Stage A: inclusive side lengths, one bit wider than a coordinate
    always_comb begin
        row_a = anchor_q[TILE_BITS-1:GRID_BITS];
        col_a = anchor_q[GRID_BITS-1:0];
        row_b = rd_data_q[TILE_BITS-1:GRID_BITS];
        col_b = rd_data_q[GRID_BITS-1:0];
        dr_d  = DIM_BITS'((row_a >= row_b) ? (row_a - row_b) : (row_b - row_a)) + DIM_BITS'(1);
        dc_d  = DIM_BITS'((col_a >= col_b) ? (col_a - col_b) : (col_b - col_a)) + DIM_BITS'(1);
    end

    // Pipeline datapath registers (qualified by the valid flags below)
    always_ff @(posedge clk) begin
        if (load_anchor_q) begin
            anchor_q <= rd_data_q;
        end
        dr_q   <= dr_d;
        dc_q   <= dc_d;
        area_q <= AREA_BITS'(dr_q) * AREA_BITS'(dc_q);
    end

    // Pipeline valid flags and stage C running maximum (ties keep the old value)
    always_ff @(posedge clk) begin
        if (rst) begin
            load_anchor_q <= 1'b0;
            rd_v_q        <= 1'b0;
            a_v_q         <= 1'b0;
            b_v_q         <= 1'b0;
            max_q         <= '0;
        end else begin
            load_anchor_q <= (state_q == S_SCAN) && anchor_phase_q;
            rd_v_q        <= issue;
            a_v_q         <= rd_v_q;
            b_v_q         <= a_v_q;
            if (b_v_q && (area_q > max_q)) begin
                max_q <= area_q;
            end
        end
    end

    assign result_valid = result_valid_q;
    assign result_area  = result_area_q;
    assign overflow     = overflow_q;

endmodule
